// File: rtl/load_store_unit_if.sv
// Load/store request bus between control/datapath and the load_store_unit.
// Latency: n/a (wiring only); write_data is combinational from address/result register.
// Backpressure: stall holds the requester while an access is in flight.
interface load_store_unit_if;
    logic        MemRead;
    logic        MemWrite;
    logic        MemtoReg;
    logic [2:0]  ls_op;
    logic [31:0] address;
    logic [31:0] store_data;
    logic [31:0] write_data;
    logic        stall;
    logic        load_valid;
    logic        misaligned;

    modport slave (
        input  MemRead, MemWrite, MemtoReg, ls_op, address, store_data,
        output write_data, stall, load_valid, misaligned
    );

    modport master (
        output MemRead, MemWrite, MemtoReg, ls_op, address, store_data,
        input  write_data, stall, load_valid, misaligned
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word load-store unit over a wait-stated word memory; optional MISALIGN_TRAP_EN traps misaligned accesses.
// Latency: WAIT_CYCLES+2 cycles per access (request, BUSY x WAIT_CYCLES, DONE); write_data bypass is zero latency.
// Backpressure: stall is high in the request cycle and through BUSY; new requests are ignored until IDLE.
module load_store_unit #(
    parameter int MEM_WORDS   = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    load_store_unit_if.slave bus
);
    localparam int AW = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW+1:0]   addr_q, addr_d;
    logic [31:0]     sdat_q, sdat_d;
    logic [2:0]      op_q, op_d;
    logic            st_q, st_d;
    logic [31:0]     result_q, result_d;

    logic [31:0]     mem [MEM_WORDS];

    logic            req;
    logic            mis_in;
    logic            stall_c;
    logic            load_valid_c;
    logic            misaligned_c;
    logic            mem_we;
    logic [1:0]      lo;
    logic [AW-1:0]   idx;
    logic [31:0]     rword;
    logic [31:0]     shifted;
    logic [31:0]     load_ext;
    logic [31:0]     mask;
    logic [31:0]     wdat;

    assign req = bus.MemRead | bus.MemWrite;

`ifdef MISALIGN_TRAP_EN
    assign mis_in = ((bus.ls_op[1:0] == 2'b01) && bus.address[0]) ||
                    (bus.ls_op[1] && (bus.address[1:0] != 2'b00));
`else
    assign mis_in = 1'b0;
`endif

    // Low address bits forced to natural alignment for the access size.
    always_comb begin
        lo = 2'b00;
        case (op_q[1:0])
            2'b00:   lo = addr_q[1:0];
            2'b01:   lo = {addr_q[1], 1'b0};
            default: lo = 2'b00;
        endcase
    end

    assign idx     = addr_q[AW+1:2];
    assign rword   = mem[idx];
    assign shifted = rword >> {lo, 3'b000};

    always_comb begin
        load_ext = rword;
        mask     = 32'hFFFF_FFFF;
        wdat     = sdat_q;
        case (op_q[1:0])
            2'b00: begin
                load_ext = {{24{~op_q[2] & shifted[7]}}, shifted[7:0]};
                mask     = 32'h0000_00FF << {lo, 3'b000};
                wdat     = {4{sdat_q[7:0]}};
            end
            2'b01: begin
                load_ext = {{16{~op_q[2] & shifted[15]}}, shifted[15:0]};
                mask     = 32'h0000_FFFF << {lo, 3'b000};
                wdat     = {2{sdat_q[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        sdat_d       = sdat_q;
        op_d         = op_q;
        st_d         = st_q;
        result_d     = result_q;
        mem_we       = 1'b0;
        stall_c      = 1'b0;
        load_valid_c = 1'b0;
        misaligned_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (mis_in) begin
                        misaligned_c = 1'b1;
                        if (!bus.MemWrite) result_d = '0;
                    end else begin
                        stall_c = 1'b1;
                        state_d = BUSY;
                        cnt_d   = 4'(WAIT_CYCLES);
                        addr_d  = bus.address[AW+1:0];
                        sdat_d  = bus.store_data;
                        op_d    = bus.ls_op;
                        st_d    = bus.MemWrite;
                    end
                end
            end
            BUSY: begin
                stall_c = 1'b1;
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                    cnt_d   = 4'd0;
                    if (st_q) mem_we   = 1'b1;
                    else      result_d = load_ext;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                load_valid_c = ~st_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= '0;
            sdat_q   <= '0;
            op_q     <= 3'b000;
            st_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            sdat_q   <= sdat_d;
            op_q     <= op_d;
            st_q     <= st_d;
            result_q <= result_d;
        end
    end

    // Memory contents survive reset; a store aborted by reset never reaches here.
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx] <= (rword & ~mask) | (wdat & mask);
    end

    assign bus.write_data = bus.MemtoReg ? result_q : bus.address;
    assign bus.stall      = stall_c;
    assign bus.load_valid = load_valid_c;
    assign bus.misaligned = misaligned_c;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (MEM_WORDS=64, WAIT_CYCLES=2).
module tb_load_store_unit;
    localparam int WAIT = 2;

    logic clk;
    logic reset;
    int   nchk;
    int   npass;
    int   nfail;

    load_store_unit_if bus_if();

    load_store_unit #(.MEM_WORDS(64), .WAIT_CYCLES(WAIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic rd, input logic wr, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp, input string tag);
        @(negedge clk);
        bus_if.MemRead    = rd;
        bus_if.MemWrite   = wr;
        bus_if.ls_op      = op;
        bus_if.address    = a;
        bus_if.store_data = d;
        bus_if.MemtoReg   = 1'b1;
        #1;
        chk({tag, ":stall_req"}, 32'(bus_if.stall), 32'd1);
        chk({tag, ":mis_req"}, 32'(bus_if.misaligned), 32'd0);
        @(negedge clk);
        bus_if.MemRead  = 1'b0;
        bus_if.MemWrite = 1'b0;
        for (int i = 0; i < WAIT; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk({tag, ":stall_busy"}, 32'(bus_if.stall), 32'd1);
            chk({tag, ":lv_busy"}, 32'(bus_if.load_valid), 32'd0);
        end
        @(negedge clk);
        #1;
        chk({tag, ":stall_done"}, 32'(bus_if.stall), 32'd0);
        chk({tag, ":lv_done"}, 32'(bus_if.load_valid), 32'(rd & ~wr));
        if (rd && !wr) chk({tag, ":data"}, bus_if.write_data, exp);
    endtask

    initial begin
        nchk  = 0;
        npass = 0;
        nfail = 0;
        reset = 1'b0;
        bus_if.MemRead    = 1'b0;
        bus_if.MemWrite   = 1'b0;
        bus_if.MemtoReg   = 1'b1;
        bus_if.ls_op      = 3'b011;
        bus_if.address    = 32'h0;
        bus_if.store_data = 32'h0;

        #3;
        chk("rst_stall", 32'(bus_if.stall), 32'd0);
        chk("rst_lv", 32'(bus_if.load_valid), 32'd0);
        chk("rst_mis", 32'(bus_if.misaligned), 32'd0);
        chk("rst_result", bus_if.write_data, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // ALU-result bypass, same cycle
        @(negedge clk);
        bus_if.MemtoReg = 1'b0;
        bus_if.address  = 32'h0000_002A;
        #1;
        chk("bypass_data", bus_if.write_data, 32'h0000_002A);
        chk("bypass_stall", 32'(bus_if.stall), 32'd0);

        access(1'b0, 1'b1, 3'b011, 32'h10, 32'h89AB_CDEF, 32'h0, "sw_10");
        access(1'b1, 1'b0, 3'b011, 32'h10, 32'h0, 32'h89AB_CDEF, "lw_10");

        access(1'b0, 1'b1, 3'b000, 32'h13, 32'h0000_00F0, 32'h0, "sb_13");
        access(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFF_FFF0, "lb_13");
        access(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 32'h0000_00F0, "lbu_13");
        access(1'b1, 1'b0, 3'b011, 32'h10, 32'h0, 32'hF0AB_CDEF, "lw_10b");

        access(1'b1, 1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFF_CDEF, "lh_10");
        access(1'b1, 1'b0, 3'b101, 32'h12, 32'h0, 32'h0000_F0AB, "lhu_12");
        access(1'b1, 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF_F0AB, "lh_12");
        access(1'b1, 1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFF_FFCD, "lb_11");
        access(1'b1, 1'b0, 3'b100, 32'h10, 32'h0, 32'h0000_00EF, "lbu_10");

        access(1'b0, 1'b1, 3'b001, 32'h12, 32'h0000_5566, 32'h0, "sh_12");
        access(1'b1, 1'b0, 3'b011, 32'h10, 32'h0, 32'h5566_CDEF, "lw_10c");
        access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h5566_CDEF, "lw_op10");

        // Both request bits high behaves as a store
        access(1'b1, 1'b1, 3'b011, 32'h14, 32'hA5A5_A5A5, 32'h0, "rdwr_14");
        access(1'b1, 1'b0, 3'b011, 32'h14, 32'h0, 32'hA5A5_A5A5, "lw_14");

`ifdef MISALIGN_TRAP_EN
        @(negedge clk);
        bus_if.MemRead  = 1'b1;
        bus_if.ls_op    = 3'b011;
        bus_if.address  = 32'h12;
        bus_if.MemtoReg = 1'b1;
        #1;
        chk("mis_pulse", 32'(bus_if.misaligned), 32'd1);
        chk("mis_stall", 32'(bus_if.stall), 32'd0);
        @(negedge clk);
        bus_if.MemRead = 1'b0;
        #1;
        chk("mis_end", 32'(bus_if.misaligned), 32'd0);
        chk("mis_data", bus_if.write_data, 32'h0);
        chk("mis_stall2", 32'(bus_if.stall), 32'd0);
`else
        access(1'b1, 1'b0, 3'b011, 32'h12, 32'h0, 32'h5566_CDEF, "lw_12_align");
`endif

        // Reset during BUSY aborts the store
        access(1'b0, 1'b1, 3'b011, 32'h20, 32'h1111_1111, 32'h0, "sw_20_old");
        @(negedge clk);
        bus_if.MemWrite   = 1'b1;
        bus_if.ls_op      = 3'b011;
        bus_if.address    = 32'h20;
        bus_if.store_data = 32'h2222_2222;
        bus_if.MemtoReg   = 1'b1;
        @(negedge clk);
        bus_if.MemWrite = 1'b0;
        #1;
        chk("abort_busy_stall", 32'(bus_if.stall), 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_stall", 32'(bus_if.stall), 32'd0);
        chk("abort_lv", 32'(bus_if.load_valid), 32'd0);
        chk("abort_result", bus_if.write_data, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        access(1'b1, 1'b0, 3'b011, 32'h20, 32'h0, 32'h1111_1111, "lw_20_old");

        // Address wrap modulo MEM_WORDS*4
        access(1'b0, 1'b1, 3'b011, 32'h100, 32'hCAFE_F00D, 32'h0, "sw_100");
        access(1'b1, 1'b0, 3'b011, 32'h000, 32'h0, 32'hCAFE_F00D, "lw_000");

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
